// File: rtl/commit_safety_scheduler.sv
// Commit-safety scheduler: holds one instruction id per requester (post office,
// mailbox) until it matches the graduation head, then issues a single one-cycle
// grant. Each head grants at most once, simultaneous claims are arbitrated
// round-robin, and a per-requester watchdog flags requests that have stalled.
module commit_safety_scheduler #(
  parameter int ID_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                po_req_valid,
  input  logic [ID_WIDTH-1:0] po_req_id,
  output logic                po_req_ready,
  output logic                po_grant,
  input  logic                mb_req_valid,
  input  logic [ID_WIDTH-1:0] mb_req_id,
  output logic                mb_req_ready,
  output logic                mb_grant,
  input  logic                cu_head_valid,
  input  logic [ID_WIDTH-1:0] cu_head_id,
  input  logic                cu_flush,
  output logic                csu_head_claimed,
  output logic [1:0]          csu_timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_M1 = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  // Index 0 is the post office, index 1 is the mailbox.
  logic [1:0]          r_state [2];
  logic [ID_WIDTH-1:0] r_pend  [2];
  logic [CNT_WIDTH-1:0] r_cnt  [2];
  logic [1:0]          r_timeout;
  logic                r_claimed;
  logic [ID_WIDTH-1:0] r_claim_id;
  logic                r_rr_po;   // 1: post office wins a tie

  logic [1:0]          w_req_valid;
  logic [ID_WIDTH-1:0] w_req_id [2];
  logic [1:0]          w_ready;
  logic [1:0]          w_elig;
  logic [1:0]          w_win;
  logic [1:0]          w_cnt_hit;

  assign w_req_valid = {mb_req_valid, po_req_valid};
  assign w_req_id[0] = po_req_id;
  assign w_req_id[1] = mb_req_id;

  // Readiness, eligibility, round-robin winner and watchdog-threshold decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_ready   = '0;
    w_elig    = '0;
    w_win     = '0;
    w_cnt_hit = '0;
    for (int i = 0; i < 2; i++) begin
      w_ready[i]   = (r_state[i] == ST_IDLE) && !cu_flush;
      w_elig[i]    = (r_state[i] == ST_WAIT) && cu_head_valid &&
                     (r_pend[i] == cu_head_id) && !r_claimed;
      w_cnt_hit[i] = (r_state[i] == ST_WAIT) && (r_cnt[i] >= TIMEOUT_M1);
    end
    w_win[0] = w_elig[0] && (!w_elig[1] ||  r_rr_po) && !cu_flush;
    w_win[1] = w_elig[1] && (!w_elig[0] || !r_rr_po) && !cu_flush;
  end

  // Per-requester FSM, pending id capture and saturating watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= ST_IDLE;
        r_pend[i]  <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        case (r_state[i])
          ST_IDLE: begin
            if (w_ready[i] && w_req_valid[i]) begin
              r_pend[i]  <= w_req_id[i];
              r_state[i] <= ST_WAIT;
              r_cnt[i]   <= '0;
            end
          end
          ST_WAIT: begin
            if (cu_flush)      r_state[i] <= ST_IDLE;
            else if (w_win[i]) r_state[i] <= ST_GRANT;
            if (r_cnt[i] != TIMEOUT_C) r_cnt[i] <= r_cnt[i] + CNT_ONE;
          end
          ST_GRANT: r_state[i] <= ST_IDLE;
          default:  r_state[i] <= ST_IDLE;
        endcase
        if (cu_flush) r_cnt[i] <= '0;
      end
    end
  end

  // Sticky timeout flags, cleared only by flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_timeout <= '0;
    else if (cu_flush) r_timeout <= '0;
    else               r_timeout <= r_timeout | w_cnt_hit;
  end

  // Head-claim tracking and round-robin pointer update on each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_claimed  <= 1'b0;
      r_claim_id <= '0;
      r_rr_po    <= 1'b1;
    end else if (cu_flush) begin
      r_claimed  <= 1'b0;
    end else if (|w_win) begin
      r_claimed  <= 1'b1;
      r_claim_id <= cu_head_id;
      r_rr_po    <= w_win[1];   // mailbox won -> post office favoured next
    end else if (r_claimed && (!cu_head_valid || (cu_head_id != r_claim_id))) begin
      r_claimed  <= 1'b0;
    end
  end

  assign po_req_ready     = w_ready[0];
  assign mb_req_ready     = w_ready[1];
  assign po_grant         = (r_state[0] == ST_GRANT);
  assign mb_grant         = (r_state[1] == ST_GRANT);
  assign csu_head_claimed = r_claimed;
  assign csu_timeout      = r_timeout;

endmodule

// File: tb/tb_commit_safety_scheduler.sv
// Directed bench for commit_safety_scheduler: handoff latency, late head,
// round-robin contention, watchdog, flush and asynchronous reset.
module tb_commit_safety_scheduler;

  localparam int ID_WIDTH = 5;
  localparam int TIMEOUT_CYCLES = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                po_req_valid = 1'b0;
  logic [ID_WIDTH-1:0] po_req_id = '0;
  logic                po_req_ready;
  logic                po_grant;
  logic                mb_req_valid = 1'b0;
  logic [ID_WIDTH-1:0] mb_req_id = '0;
  logic                mb_req_ready;
  logic                mb_grant;
  logic                cu_head_valid = 1'b0;
  logic [ID_WIDTH-1:0] cu_head_id = '0;
  logic                cu_flush = 1'b0;
  logic                csu_head_claimed;
  logic [1:0]          csu_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  commit_safety_scheduler #(
    .ID_WIDTH(ID_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .po_req_valid(po_req_valid), .po_req_id(po_req_id),
    .po_req_ready(po_req_ready), .po_grant(po_grant),
    .mb_req_valid(mb_req_valid), .mb_req_id(mb_req_id),
    .mb_req_ready(mb_req_ready), .mb_grant(mb_grant),
    .cu_head_valid(cu_head_valid), .cu_head_id(cu_head_id),
    .cu_flush(cu_flush),
    .csu_head_claimed(csu_head_claimed), .csu_timeout(csu_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle flush that also drops the head, leaving both FSMs idle.
  task automatic flush_pulse();
    cu_flush = 1'b1;
    cu_head_valid = 1'b0;
    step();
    cu_flush = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_po_ready", po_req_ready, 1);
    check("rst_mb_ready", mb_req_ready, 1);
    check("rst_po_grant", po_grant, 0);
    check("rst_mb_grant", mb_grant, 0);
    check("rst_timeout", csu_timeout, 0);
    check("rst_claimed", csu_head_claimed, 0);

    // ---------------- basic handoff ----------------
    cu_head_valid = 1'b1; cu_head_id = 5'd3;
    po_req_valid = 1'b1; po_req_id = 5'd3;          // cycle 0
    step(); po_req_valid = 1'b0;                    // cycle 1
    check("basic_c1_ready", po_req_ready, 0);
    check("basic_c1_grant", po_grant, 0);
    step();                                         // cycle 2
    check("basic_c2_grant", po_grant, 1);
    check("basic_c2_ready", po_req_ready, 0);
    check("basic_c2_mb_grant", mb_grant, 0);
    check("basic_c2_claimed", csu_head_claimed, 1);
    step();                                         // cycle 3
    check("basic_c3_grant", po_grant, 0);
    check("basic_c3_ready", po_req_ready, 1);
    check("basic_c3_claimed", csu_head_claimed, 1);
    cu_head_valid = 1'b0;
    step();
    check("basic_claim_clear", csu_head_claimed, 0);

    // ---------------- late head ----------------
    cu_head_valid = 1'b1; cu_head_id = 5'd5;
    mb_req_valid = 1'b1; mb_req_id = 5'd7;          // cycle 0
    check("late_c0_ready", mb_req_ready, 1);
    for (int c = 1; c <= 10; c++) begin
      step();
      mb_req_valid = 1'b0;
      check("late_wait_grant", mb_grant, 0);
    end
    check("late_timeout", csu_timeout, 2'b10);      // set after 4 WAIT cycles
    cu_head_id = 5'd7;                              // cycle 10
    step();                                         // cycle 11
    check("late_c11_grant", mb_grant, 1);
    check("late_c11_po_grant", po_grant, 0);
    step();                                         // cycle 12
    check("late_c12_grant", mb_grant, 0);
    check("late_c12_ready", mb_req_ready, 1);
    flush_pulse();
    check("late_flush_timeout", csu_timeout, 0);

    // ---------------- contention, post office wins ----------------
    po_req_valid = 1'b1; po_req_id = 5'd4;
    mb_req_valid = 1'b1; mb_req_id = 5'd4;
    step(); po_req_valid = 1'b0; mb_req_valid = 1'b0;
    step(); cu_head_valid = 1'b1; cu_head_id = 5'd4;
    step();
    check("cont4_po_grant", po_grant, 1);
    check("cont4_mb_grant", mb_grant, 0);
    check("cont4_claimed", csu_head_claimed, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("cont4_mb_blocked", mb_grant, 0);
      check("cont4_claim_held", csu_head_claimed, 1);
    end
    flush_pulse();

    // ---------------- contention, mailbox wins ----------------
    po_req_valid = 1'b1; po_req_id = 5'd9;
    mb_req_valid = 1'b1; mb_req_id = 5'd9;
    step(); po_req_valid = 1'b0; mb_req_valid = 1'b0;
    step(); cu_head_valid = 1'b1; cu_head_id = 5'd9;
    step();
    check("cont9_mb_grant", mb_grant, 1);
    check("cont9_po_grant", po_grant, 0);
    step();
    check("cont9_po_blocked", po_grant, 0);
    flush_pulse();

    // ---------------- watchdog ----------------
    cu_head_valid = 1'b1; cu_head_id = 5'd1;
    po_req_valid = 1'b1; po_req_id = 5'd2;          // cycle 0
    step(); po_req_valid = 1'b0;                    // cycle 1
    repeat (3) step();                              // cycle 4
    check("wd_c4_timeout", csu_timeout, 2'b00);
    step();                                         // cycle 5
    check("wd_c5_timeout", csu_timeout, 2'b01);
    repeat (3) step();                              // cycle 8
    check("wd_c8_sticky", csu_timeout, 2'b01);
    cu_head_id = 5'd2;
    step();                                         // cycle 9
    check("wd_c9_grant", po_grant, 1);
    check("wd_c9_timeout", csu_timeout, 2'b01);
    step();
    check("wd_c10_timeout", csu_timeout, 2'b01);
    flush_pulse();

    // ---------------- flush ----------------
    cu_head_valid = 1'b1; cu_head_id = 5'd0;
    po_req_valid = 1'b1; po_req_id = 5'd12;
    mb_req_valid = 1'b1; mb_req_id = 5'd13;
    step(); po_req_valid = 1'b0; mb_req_valid = 1'b0;
    repeat (5) step();
    check("fl_timeout_pre", csu_timeout, 2'b11);
    cu_flush = 1'b1;
    #1;
    check("fl_po_ready_during", po_req_ready, 0);
    check("fl_mb_ready_during", mb_req_ready, 0);
    step(); cu_flush = 1'b0;
    #1;
    check("fl_po_idle", po_req_ready, 1);
    check("fl_mb_idle", mb_req_ready, 1);
    check("fl_timeout_clr", csu_timeout, 0);
    cu_head_id = 5'd12;
    for (int c = 0; c < 3; c++) begin step(); check("fl_no_po_grant", po_grant, 0); end
    cu_head_id = 5'd13;
    for (int c = 0; c < 3; c++) begin step(); check("fl_no_mb_grant", mb_grant, 0); end
    // A valid request presented during flush must not be captured.
    cu_flush = 1'b1; po_req_valid = 1'b1; po_req_id = 5'd13;
    #1;
    check("fl_idle_ready", po_req_ready, 0);
    step(); cu_flush = 1'b0; po_req_valid = 1'b0;
    #1;
    check("fl_no_capture", po_req_ready, 1);
    repeat (2) step();
    check("fl_no_capture_grant", po_grant, 0);

    // ---------------- async reset during GRANT ----------------
    cu_head_valid = 1'b1; cu_head_id = 5'd6;
    po_req_valid = 1'b1; po_req_id = 5'd6;
    step(); po_req_valid = 1'b0;
    step();
    check("ar_grant_before", po_grant, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_grant_dropped", po_grant, 0);
    check("ar_claim_dropped", csu_head_claimed, 0);
    @(negedge clk) rst = 1'b0;
    step();
    check("ar_po_ready", po_req_ready, 1);
    check("ar_mb_ready", mb_req_ready, 1);
    check("ar_grant_after", po_grant, 0);
    check("ar_timeout", csu_timeout, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_safety_scheduler.md
Name: commit_safety_scheduler

Overview:
Sequences commit-safety requests from the post office and the mailbox against the control unit's graduation head. Each requester hands over one instruction id. The block holds that id until it matches the current head, then issues a single one-cycle grant. At most one grant is issued per head. Simultaneous claims are arbitrated round-robin, and stalled requests are flagged by a per-requester watchdog.

Parameters:
ID_WIDTH, 5, width of instruction/graduation ids
TIMEOUT_CYCLES, 256, WAIT cycles before the timeout flag sets (must be >= 1)
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), watchdog counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
po_req_valid  in  1  post office request valid
po_req_id  in  ID_WIDTH  post office instruction id
po_req_ready  out  1  post office request accepted when valid&ready
po_grant  out  1  one-cycle commit-safe grant to the post office
mb_req_valid  in  1  mailbox request valid
mb_req_id  in  ID_WIDTH  mailbox instruction id
mb_req_ready  out  1  mailbox request accepted when valid&ready
mb_grant  out  1  one-cycle commit-safe grant to the mailbox
cu_head_valid  in  1  graduation head valid
cu_head_id  in  ID_WIDTH  id at the graduation head
cu_flush  in  1  synchronous pipeline flush
csu_head_claimed  out  1  the current head has already been granted
csu_timeout  out  2  sticky watchdog flags, bit0 = post office, bit1 = mailbox

Behaviour:
- Reset values (async, rst=1):
  - both FSMs in IDLE; pending ids 0; watchdog counters 0
  - grants 0; csu_timeout 0; csu_head_claimed 0
  - rr pointer favours the post office
  - readies are 1 once rst deasserts and cu_flush=0
- Per-requester FSM: IDLE -> WAIT -> GRANT -> IDLE.
  - IDLE:
    - ready = !cu_flush
    - on valid&ready, capture id into the pending register and go to WAIT
  - WAIT:
    - ready = 0
    - eligible when cu_head_valid & pending == cu_head_id & !head_claimed
    - if eligible and winning arbitration, go to GRANT
  - GRANT:
    - ready = 0
    - grant output is 1 for exactly this cycle
    - return to IDLE next cycle
- Latency:
  - accept at cycle N; WAIT from N+1
  - if the head already matches at N+1, grant is high at N+2
  - ready is high again at N+3
- Grants are registered (state decode); there is no combinational path from cu_head_* to grant.
- Arbitration:
  - if both requesters are eligible in the same cycle, the one not granted last wins
  - the rr pointer updates only on a grant
  - the loser stays in WAIT
- Head claim:
  - head_claimed sets on the cycle any FSM enters GRANT, recording the claimed head id
  - it clears when cu_head_valid=0 or cu_head_id differs from the recorded id
  - while set, no requester is eligible, so a given head produces at most one grant
- Watchdog:
  - per-requester counter cleared on entry to WAIT
  - increments each WAIT cycle and saturates at TIMEOUT_CYCLES
  - reaching TIMEOUT_CYCLES sets the csu_timeout bit, which stays set until cu_flush or rst
  - the flag does not affect granting
- Flush (synchronous, highest priority):
  - both FSMs go to IDLE next cycle
  - readies forced 0 during the flush cycle; no capture
  - a grant already in GRANT state still shows that cycle; no new GRANT entry
  - head_claimed, counters and csu_timeout are cleared
- Id compare is exact over ID_WIDTH bits. Wrap-around is the control unit's concern; equal ids always match.
- rst asserted mid-operation: everything returns to reset values immediately, and any in-flight grant is dropped.

Test Plan:
- Basic handoff: po_req id=3 at cycle 0 with head=3 valid → po_grant=1 at cycle 2 only; po_req_ready=0 at cycles 1-2 and 1 at cycle 3; mb_grant stays 0.
- Late head: mb_req id=7 while head=5; head becomes 7 at cycle 10 → mb_grant=1 at cycle 11 only.
- Contention: both requesters pending id=4, head goes 4 → po_grant first; csu_head_claimed=1 and no mb_grant until the head changes. A repeat with both pending id=9, head goes 9 → mb_grant first (round-robin).
- Watchdog: TIMEOUT_CYCLES=4, po pending id=2, head stuck at 1 → csu_timeout[0]=1 after 4 WAIT cycles and stays set; a later head=2 still grants.
- Flush: cu_flush while both are in WAIT → both in IDLE next cycle, readies 0 during the flush cycle, csu_timeout=0, no grant even when the head later matches the old ids.
- Async reset: assert rst while in GRANT → po_grant drops immediately; readies 1 after release.
